l2_port_arbiter: RTL and testbench
==================================

# l2_port_arbiter

Three-requester arbiter in front of the L2 cache's L1-side port. It shares the single 256-bit L2 port between the data cache, the instruction cache and an instruction-line prefetcher. Fixed priority is data > instruction > prefetch, with an aging override so the instruction cache cannot be starved by back-to-back data traffic. It also exports busy-state flags and wait-cycle counters for the performance-counter logic.

## Interface
- `STARVE_LIMIT`, default 4: consecutive data grants allowed while an instruction request waits; range 1-15.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `data_mem_read` in 1: D-cache line read request.
- `data_mem_write` in 1: D-cache line write-back request.
- `data_mem_addr` in 32: D-cache line address.
- `data_mem_wdata` in 256: D-cache write-back line.
- `data_mem_rdata` out 256: read line returned to the D-cache.
- `data_mem_resp` out 1: D-cache completion pulse.
- `inst_mem_read` in 1: I-cache line read request.
- `inst_mem_addr` in 32: I-cache line address.
- `inst_mem_rdata` out 256: read line returned to the I-cache.
- `inst_mem_resp` out 1: I-cache completion pulse.
- `pf_read` in 1: prefetcher line read request.
- `pf_addr` in 32: prefetch line address.
- `pf_rdata` out 256: prefetched line.
- `pf_resp` out 1: prefetch completion pulse.
- `mem_read` out 1: read request to L2.
- `mem_write` out 1: write request to L2.
- `mem_address` out 32: L2 address.
- `mem_wdata` out 256: L2 write line.
- `mem_rdata` in 256: L2 read line.
- `mem_resp` in 1: L2 completion pulse.
- `in_data_state` out 1: arbiter is serving D.
- `in_instr_state` out 1: arbiter is serving I.
- `data_wait_cycles` out 32: D wait-cycle counter.
- `inst_wait_cycles` out 32: I wait-cycle counter.

## Operation
- States: IDLE, SERVE_D, SERVE_I, SERVE_P, DONE.
- **IDLE** picks one winner per cycle, in this order:
  1. I, if `inst_mem_read` is high and `starve_cnt == STARVE_LIMIT`.
  2. D, if `data_mem_read` or `data_mem_write` is high.
  3. I, if `inst_mem_read` is high.
  4. P, if `pf_read` is high.
  5. Otherwise stay in IDLE.
- On grant, register the winner's address and wdata and the op type into `req_*`, then enter the matching SERVE state.
- If D asserts read and write together, it is treated as a write.
- **SERVE_x**:
  - `mem_read`/`mem_write` come from the registered op; `mem_address`/`mem_wdata` come from the registered copies.
  - Hold the request until `mem_resp` is seen.
  - In the `mem_resp` cycle, `x_resp = 1` and `x_rdata = mem_rdata` (combinational pass-through). Then go to DONE.
- **DONE**: no L2 request is driven and no resp is asserted for one cycle. The next state is IDLE. This lets the requester drop its request, so the same request is never re-granted.
- **starve_cnt** (4 bits):
  - +1 on a D grant while `inst_mem_read` is high.
  - Cleared on an I grant, and in any IDLE cycle with `inst_mem_read` low.
  - Saturates at STARVE_LIMIT.
- Prefetch is granted only when D and I are both idle in IDLE. Once granted it runs to completion, and a later D/I request waits for it.
- **Wait counters** (saturating at 0xFFFF_FFFF):
  - `data_wait_cycles` +1 every cycle that (`data_mem_read | data_mem_write`) is high and `data_mem_resp` is low.
  - `inst_wait_cycles` counts the same way for I.
- `in_data_state`/`in_instr_state` are decoded from the registered state (SERVE_D / SERVE_I), so they are glitch-free.
- Unserved ports always drive resp 0 and rdata 0.

## Timing
- **Reset values**:
  - state IDLE.
  - All `*_resp`, `mem_read`, `mem_write`, `in_*_state` = 0.
  - `mem_address`, `mem_wdata`, all rdata = 0.
  - `starve_cnt` = 0; both wait counters = 0.
- Reset mid-transaction returns to IDLE next edge. The L2 transaction is abandoned, since the L2 resets on the same `rst`.
- Request seen in IDLE at cycle 0: `mem_read`/`mem_write` is high at cycle 1.
- If L2 responds at cycle k, the requester's resp is high at cycle k only. DONE is at k+1, IDLE at k+2, and the earliest next grant decision is at k+2.
- Minimum request-to-resp latency is 2 cycles (L2 responding at cycle 1 gives resp at cycle 1).
- Back-to-back throughput is one transaction per (L2 latency + 2) cycles.
- `mem_resp` arriving in IDLE or DONE is ignored.
- Requests arriving during SERVE_x or DONE are arbitrated only on return to IDLE.
- Requesters must hold address and wdata stable until resp; the arbiter uses only the copies latched at grant.

## Test plan
- **Single D read**: `data_mem_read`, addr 0x0000_1000, L2 returns line 0xAA..A after 3 cycles. Required: `mem_read` high cycles 1-3, `mem_address` 0x1000, `data_mem_resp` for exactly one cycle with rdata 0xAA..A, `in_data_state` high cycles 1-3.
- **Simultaneous D write + I read**: D write (addr 0x2000, wdata 0x55..5) and I read at cycle 0. Required: D is served first (`mem_write`=1, wdata 0x55..5); I is granted in the IDLE after DONE; `inst_wait_cycles` equals the I request-to-resp cycle count.
- **Starvation**: D requests continuously, I requests continuously, STARVE_LIMIT=4. Required: grant order D,D,D,D,I,D…; `starve_cnt` returns to 0 after the I grant.
- **Prefetch lowest priority**: `pf_read` and `inst_mem_read` raised together. Required: I is served first, then P. A D request raised during SERVE_P waits until P's `pf_resp` + DONE.
- **Reset mid-transaction**: assert `rst` in SERVE_I before `mem_resp`. Required: next cycle all outputs 0, state IDLE, counters 0; a late `mem_resp` produces no resp.
- **Counter saturation**: force `data_wait_cycles` to 0xFFFF_FFFE, then hold D waiting 3 cycles. Required: counter reads 0xFFFF_FFFF and holds.

Source files
------------

// File: rtl/l2_port_arbiter_if.sv
// Signal bundle between the L1 requesters (D-cache, I-cache, prefetcher),
// the L2 port arbiter and the single 256-bit L2 port.
interface l2_port_arbiter_if;
    logic         data_mem_read;
    logic         data_mem_write;
    logic [31:0]  data_mem_addr;
    logic [255:0] data_mem_wdata;
    logic [255:0] data_mem_rdata;
    logic         data_mem_resp;

    logic         inst_mem_read;
    logic [31:0]  inst_mem_addr;
    logic [255:0] inst_mem_rdata;
    logic         inst_mem_resp;

    logic         pf_read;
    logic [31:0]  pf_addr;
    logic [255:0] pf_rdata;
    logic         pf_resp;

    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;

    logic         in_data_state;
    logic         in_instr_state;
    logic [31:0]  data_wait_cycles;
    logic [31:0]  inst_wait_cycles;

    // Requester / L2 side of the bundle
    modport master (
        output data_mem_read, data_mem_write, data_mem_addr, data_mem_wdata,
               inst_mem_read, inst_mem_addr, pf_read, pf_addr,
               mem_rdata, mem_resp,
        input  data_mem_rdata, data_mem_resp, inst_mem_rdata, inst_mem_resp,
               pf_rdata, pf_resp, mem_read, mem_write, mem_address, mem_wdata,
               in_data_state, in_instr_state, data_wait_cycles, inst_wait_cycles
    );

    // Arbiter side of the bundle
    modport slave (
        input  data_mem_read, data_mem_write, data_mem_addr, data_mem_wdata,
               inst_mem_read, inst_mem_addr, pf_read, pf_addr,
               mem_rdata, mem_resp,
        output data_mem_rdata, data_mem_resp, inst_mem_rdata, inst_mem_resp,
               pf_rdata, pf_resp, mem_read, mem_write, mem_address, mem_wdata,
               in_data_state, in_instr_state, data_wait_cycles, inst_wait_cycles
    );
endinterface

// File: rtl/l2_port_arbiter.sv
// Shares the L2 port between D-cache, I-cache and prefetcher: fixed priority
// D > I > P with an aging override for I, plus busy flags and wait counters.
module l2_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    l2_port_arbiter_if.slave bus
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SERVE_D = 3'd1;
    localparam logic [2:0] ST_SERVE_I = 3'd2;
    localparam logic [2:0] ST_SERVE_P = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [2:0]   state_reg;
    logic [2:0]   state_next;
    logic [31:0]  req_addr_reg;
    logic [255:0] req_wdata_reg;
    logic         req_write_reg;
    logic [3:0]   starve_cnt_reg;
    logic [31:0]  data_wait_cycles_reg;
    logic [31:0]  inst_wait_cycles_reg;

    logic         data_req;
    logic         inst_req;
    logic         pf_req;
    logic         serving;
    logic [2:0]   serve_vec;
    logic [2:0]   resp_vec;
    logic [255:0] rdata_vec [3];

    assign data_req = bus.data_mem_read | bus.data_mem_write;
    assign inst_req = bus.inst_mem_read;
    assign pf_req   = bus.pf_read;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                // Aging override first, then plain fixed priority
                if (inst_req && starve_cnt_reg == LIMIT) begin
                    state_next = ST_SERVE_I;
                end else if (data_req) begin
                    state_next = ST_SERVE_D;
                end else if (inst_req) begin
                    state_next = ST_SERVE_I;
                end else if (pf_req) begin
                    state_next = ST_SERVE_P;
                end
            end
            ST_SERVE_D, ST_SERVE_I, ST_SERVE_P: begin
                if (bus.mem_resp) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            req_addr_reg   <= '0;
            req_wdata_reg  <= '0;
            req_write_reg  <= 1'b0;
            starve_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE) begin
                case (state_next)
                    ST_SERVE_D: begin
                        req_addr_reg  <= bus.data_mem_addr;
                        req_wdata_reg <= bus.data_mem_wdata;
                        req_write_reg <= bus.data_mem_write;
                    end
                    ST_SERVE_I: begin
                        req_addr_reg  <= bus.inst_mem_addr;
                        req_wdata_reg <= '0;
                        req_write_reg <= 1'b0;
                    end
                    ST_SERVE_P: begin
                        req_addr_reg  <= bus.pf_addr;
                        req_wdata_reg <= '0;
                        req_write_reg <= 1'b0;
                    end
                    default: begin
                    end
                endcase
                // Count D grants that overtake a waiting I request
                if (!inst_req || state_next == ST_SERVE_I) begin
                    starve_cnt_reg <= '0;
                end else if (state_next == ST_SERVE_D && starve_cnt_reg != LIMIT) begin
                    starve_cnt_reg <= starve_cnt_reg + 4'd1;
                end
            end
        end
    end

    assign serve_vec = {state_reg == ST_SERVE_P, state_reg == ST_SERVE_I, state_reg == ST_SERVE_D};
    assign serving   = |serve_vec;

    assign bus.mem_read    = serving & ~req_write_reg;
    assign bus.mem_write   = serving & req_write_reg;
    assign bus.mem_address = serving ? req_addr_reg : '0;
    assign bus.mem_wdata   = serving ? req_wdata_reg : '0;

    // Port order in the vectors: 0 = D, 1 = I, 2 = P
    for (genvar gi = 0; gi < 3; gi++) begin : g_port
        assign resp_vec[gi]  = serve_vec[gi] & bus.mem_resp;
        assign rdata_vec[gi] = resp_vec[gi] ? bus.mem_rdata : '0;
    end

    assign bus.data_mem_resp  = resp_vec[0];
    assign bus.inst_mem_resp  = resp_vec[1];
    assign bus.pf_resp        = resp_vec[2];
    assign bus.data_mem_rdata = rdata_vec[0];
    assign bus.inst_mem_rdata = rdata_vec[1];
    assign bus.pf_rdata       = rdata_vec[2];

    assign bus.in_data_state  = serve_vec[0];
    assign bus.in_instr_state = serve_vec[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            data_wait_cycles_reg <= '0;
            inst_wait_cycles_reg <= '0;
        end else begin
            if (data_req && !resp_vec[0] && data_wait_cycles_reg != '1) begin
                data_wait_cycles_reg <= data_wait_cycles_reg + 32'd1;
            end
            if (inst_req && !resp_vec[1] && inst_wait_cycles_reg != '1) begin
                inst_wait_cycles_reg <= inst_wait_cycles_reg + 32'd1;
            end
        end
    end

    assign bus.data_wait_cycles = data_wait_cycles_reg;
    assign bus.inst_wait_cycles = inst_wait_cycles_reg;
endmodule

// File: tb/tb_l2_port_arbiter.sv
// Randomized and directed bench for l2_port_arbiter against a transaction-level
// reference model (current owner, cool-down flag, saturating counters).
module tb_l2_port_arbiter;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l2_port_arbiter_if bus();

    l2_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Stimulus held between cycles
    logic         d_rd, d_wr, i_rd, p_rd, l2_resp, rst_req;
    logic [31:0]  d_addr, i_addr, p_addr;
    logic [255:0] d_wdata, l2_rdata;

    // Reference model: 0 = nobody, 1 = D, 2 = I, 3 = P
    int           m_owner;
    bit           m_cool;
    bit           m_wr;
    logic [31:0]  m_addr;
    logic [255:0] m_wdata;
    int           m_starve;
    longint       m_dwait, m_iwait;

    bit last_d, last_i, last_p;
    int prev_own;
    int dut_log[$];

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit chk_cnt);
        bit e_d, e_i, e_p, serve;
        int win, own;
        bus.data_mem_read  = d_rd;
        bus.data_mem_write = d_wr;
        bus.data_mem_addr  = d_addr;
        bus.data_mem_wdata = d_wdata;
        bus.inst_mem_read  = i_rd;
        bus.inst_mem_addr  = i_addr;
        bus.pf_read        = p_rd;
        bus.pf_addr        = p_addr;
        bus.mem_resp       = l2_resp;
        bus.mem_rdata      = l2_rdata;
        rst                = rst_req;
        #2;
        serve = (m_owner != 0);
        e_d = (m_owner == 1) && l2_resp;
        e_i = (m_owner == 2) && l2_resp;
        e_p = (m_owner == 3) && l2_resp;
        check_val("mem_read", bus.mem_read, serve && !m_wr);
        check_val("mem_write", bus.mem_write, serve && m_wr);
        if (serve) begin
            check_val("mem_address", bus.mem_address, m_addr);
            if (m_wr) check_val("mem_wdata", bus.mem_wdata, m_wdata);
        end
        check_val("d_resp", bus.data_mem_resp, e_d);
        check_val("i_resp", bus.inst_mem_resp, e_i);
        check_val("p_resp", bus.pf_resp, e_p);
        check_val("d_rdata", bus.data_mem_rdata, e_d ? l2_rdata : 256'd0);
        check_val("i_rdata", bus.inst_mem_rdata, e_i ? l2_rdata : 256'd0);
        check_val("p_rdata", bus.pf_rdata, e_p ? l2_rdata : 256'd0);
        check_val("in_data_state", bus.in_data_state, m_owner == 1);
        check_val("in_instr_state", bus.in_instr_state, m_owner == 2);
        if (chk_cnt) begin
            check_val("data_wait_cycles", bus.data_wait_cycles, m_dwait);
            check_val("inst_wait_cycles", bus.inst_wait_cycles, m_iwait);
        end
        own = bus.in_data_state ? 1 : bus.in_instr_state ? 2 : (bus.mem_read || bus.mem_write) ? 3 : 0;
        if (own != 0 && own != prev_own) dut_log.push_back(own);
        prev_own = own;
        last_d = e_d;
        last_i = e_i;
        last_p = e_p;
        @(posedge clk);
        if (rst_req) begin
            m_owner = 0; m_cool = 0; m_wr = 0; m_starve = 0; m_dwait = 0; m_iwait = 0;
        end else begin
            if ((d_rd || d_wr) && !e_d && m_dwait < 64'd4294967295) m_dwait++;
            if (i_rd && !e_i && m_iwait < 64'd4294967295) m_iwait++;
            if (m_cool) begin
                m_cool = 0;
            end else if (m_owner != 0) begin
                if (l2_resp) begin
                    m_owner = 0;
                    m_cool  = 1;
                end
            end else begin
                win = 0;
                if (i_rd && m_starve == LIMIT) win = 2;
                else if (d_rd || d_wr)         win = 1;
                else if (i_rd)                 win = 2;
                else if (p_rd)                 win = 3;
                if (win == 2 || !i_rd) m_starve = 0;
                else if (win == 1) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
                m_owner = win;
                case (win)
                    1: begin m_addr = d_addr; m_wdata = d_wdata; m_wr = d_wr; end
                    2: begin m_addr = i_addr; m_wdata = '0; m_wr = 0; end
                    3: begin m_addr = p_addr; m_wdata = '0; m_wr = 0; end
                    default: begin end
                endcase
            end
        end
        #1;
    endtask

    // req_mode: 0 drop on resp, 1 hold, 2 random; l2_kind: 0 silent, 1 immediate, 2 random
    task automatic run(input int n, input int req_mode, input int l2_kind);
        for (int c = 0; c < n; c++) begin
            if (req_mode != 1) begin
                if (last_d) begin d_rd = 0; d_wr = 0; end
                if (last_i) i_rd = 0;
                if (last_p) p_rd = 0;
            end
            if (req_mode == 2) begin
                if (!last_d && !(d_rd || d_wr) && $urandom_range(0, 2) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       d_rd = 1;
                        1:       d_wr = 1;
                        default: begin d_rd = 1; d_wr = 1; end
                    endcase
                    d_addr  = $urandom;
                    d_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                end
                if (!last_i && !i_rd && $urandom_range(0, 2) == 0) begin
                    i_rd = 1; i_addr = $urandom;
                end
                if (!last_p && !p_rd && $urandom_range(0, 3) == 0) begin
                    p_rd = 1; p_addr = $urandom;
                end
            end
            l2_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            case (l2_kind)
                0:       l2_resp = 0;
                1:       l2_resp = (m_owner != 0);
                default: l2_resp = (m_owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            endcase
            step(1);
        end
    endtask

    initial begin
        int base;
        int exp_starve [6];
        exp_starve = '{1, 1, 1, 1, 2, 1};
        d_rd = 0; d_wr = 0; i_rd = 0; p_rd = 0; l2_resp = 0; rst_req = 1;
        d_addr = 0; i_addr = 0; p_addr = 0; d_wdata = 0; l2_rdata = 0;
        m_owner = 0; m_cool = 0; m_wr = 0; m_addr = 0; m_wdata = 0;
        m_starve = 0; m_dwait = 0; m_iwait = 0;
        last_d = 0; last_i = 0; last_p = 0; prev_own = 0;
        bus.data_mem_read = 0; bus.data_mem_write = 0; bus.inst_mem_read = 0; bus.pf_read = 0;
        bus.mem_resp = 0; bus.mem_rdata = 0;
        bus.data_mem_addr = 0; bus.data_mem_wdata = 0; bus.inst_mem_addr = 0; bus.pf_addr = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst_req = 0;
        check_val("rst_mem_address", bus.mem_address, 32'd0);
        check_val("rst_mem_wdata", bus.mem_wdata, 256'd0);
        step(1);

        // Single D read, L2 answers on the third serving cycle
        d_rd = 1; d_addr = 32'h0000_1000;
        run(3, 0, 0);
        check_val("d_read_address", bus.mem_address, 32'h0000_1000);
        l2_rdata = {32{8'hAA}}; l2_resp = 1;
        step(1);
        run(3, 0, 0);

        // D write and I read together: D first, then I
        base = dut_log.size();
        d_wr = 1; d_addr = 32'h0000_2000; d_wdata = {32{8'h55}};
        i_rd = 1; i_addr = 32'h0000_3000;
        run(10, 0, 1);
        check_val("dw_ir_first", dut_log[base], 1);
        check_val("dw_ir_second", dut_log[base + 1], 2);

        // Starvation: D and I both held high
        base = dut_log.size();
        d_rd = 1; i_rd = 1;
        run(20, 1, 1);
        for (int k = 0; k < 6; k++) check_val($sformatf("starve_grant%0d", k), dut_log[base + k], exp_starve[k]);
        d_rd = 0; i_rd = 0;
        run(4, 0, 0);

        // Prefetch loses to I; a D raised during SERVE_P waits for it
        base = dut_log.size();
        i_rd = 1; p_rd = 1; i_addr = 32'h0000_4000; p_addr = 32'h0000_5000;
        run(3, 0, 1);
        run(2, 0, 0);
        d_rd = 1; d_addr = 32'h0000_6000;
        run(2, 0, 0);
        run(8, 0, 1);
        check_val("pf_order0", dut_log[base], 2);
        check_val("pf_order1", dut_log[base + 1], 3);
        check_val("pf_order2", dut_log[base + 2], 1);

        // Reset in SERVE_I before the L2 answers, then a late mem_resp
        i_rd = 1; i_addr = 32'h0000_7000;
        run(2, 0, 0);
        rst_req = 1;
        step(1);
        rst_req = 0; i_rd = 0; l2_resp = 1;
        step(1);
        l2_resp = 0;
        step(1);

        // Data wait counter saturation
        d_rd = 1; d_addr = 32'h0000_8000;
        run(2, 0, 0);
        force dut.data_wait_cycles_reg = 32'hFFFF_FFFE;
        m_dwait = 64'h0000_0000_FFFF_FFFE;
        step(1);
        release dut.data_wait_cycles_reg;
        step(0);
        repeat (3) step(1);
        check_val("sat_data_wait", bus.data_wait_cycles, 32'hFFFF_FFFF);
        run(4, 0, 1);

        // Randomized traffic; restart counters from a known state
        rst_req = 1; step(1); rst_req = 0;
        run(3000, 2, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
